// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared types, limits and pointer-code helpers for the dual-clock FIFO
// write-side and read-side controllers.
//
// Contents:
//   FIFO_MIN_ADDR_WIDTH / FIFO_MAX_ADDR_WIDTH : legal address width range
//   fifo_ptr_t : widest pointer container; narrower pointers are zero-extended
//   bin2gray() : binary -> reflected Gray
//   gray2bin() : reflected Gray -> binary (XOR prefix from the MSB)
//
// The helpers work at the widest pointer width. Zero-extending a narrower
// value leaves its conversion unchanged, so callers cast in, convert, and
// truncate back to their own width.
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int unsigned FIFO_MIN_ADDR_WIDTH = 2;
   localparam int unsigned FIFO_MAX_ADDR_WIDTH = 12;
   localparam int unsigned FIFO_MAX_PTR_W      = FIFO_MAX_ADDR_WIDTH + 1;

   typedef logic [FIFO_MAX_PTR_W-1:0] fifo_ptr_t;

   function automatic fifo_ptr_t bin2gray(input fifo_ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic fifo_ptr_t gray2bin(input fifo_ptr_t g);
      fifo_ptr_t b;
      b = '0;
      b[FIFO_MAX_PTR_W-1] = g[FIFO_MAX_PTR_W-1];
      for (int unsigned k = 2; k <= FIFO_MAX_PTR_W; k++) begin
         b[FIFO_MAX_PTR_W-k] = b[FIFO_MAX_PTR_W-k+1] ^ g[FIFO_MAX_PTR_W-k];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// -----------------------------------------------------------------------------
// fifo_gray2bin
// Combinational, width-parametrised Gray-to-binary converter. Shared by the
// write-side level option and the read-side controller.
//
// Parameters:
//   WIDTH  : code width in bits (up to fifo_pkg::FIFO_MAX_PTR_W)
// Ports:
//   i_gray : Gray-coded input
//   o_bin  : equivalent binary value
// -----------------------------------------------------------------------------
module fifo_gray2bin
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_bin
);

   assign o_bin = WIDTH'(gray2bin(fifo_ptr_t'(i_gray)));

endmodule

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side controller of the dual-clock FIFO, entirely in the w_clk domain.
// Keeps the binary write pointer, publishes its Gray form to the read-domain
// synchroniser, drives the memory write port, and flags full / overflow.
//
// Parameters:
//   ADDR_WIDTH : memory address width, depth = 2**ADDR_WIDTH (2..12)
//   AF_THRESH  : almost-full threshold in entries (level option only)
// Ports:
//   w_clk        in   write clock, rising edge
//   wrst         in   synchronous active-high reset
//   w_inc        in   write request
//   wq2_rptr     in   Gray read pointer, synchronised into w_clk
//   ovf_clr      in   clears the sticky overflow flag
//   w_en         out  memory write strobe (w_inc & ~wfull)
//   waddr        out  memory write address
//   gray_wptr    out  registered Gray write pointer
//   wfull        out  registered full flag
//   wovf         out  sticky overflow (write attempted while full)
//   wlevel       out  registered fill level      (FIFO_WR_LEVEL_EN only)
//   walmost_full out  wlevel >= AF_THRESH        (FIFO_WR_LEVEL_EN only)
//
// Optional feature macro: FIFO_WR_LEVEL_EN
// -----------------------------------------------------------------------------
module fifo_wr_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned AF_THRESH  = 2**ADDR_WIDTH - 2
) (
   input  logic                  w_clk,
   input  logic                  wrst,
   input  logic                  w_inc,
   input  logic [ADDR_WIDTH:0]   wq2_rptr,
   input  logic                  ovf_clr,
   output logic                  w_en,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [ADDR_WIDTH:0]   gray_wptr,
   output logic                  wfull,
   output logic                  wovf
`ifdef FIFO_WR_LEVEL_EN
   ,
   output logic [ADDR_WIDTH:0]   wlevel,
   output logic                  walmost_full
`endif
);

   localparam int unsigned PTR_W = ADDR_WIDTH + 1;

   if (ADDR_WIDTH < FIFO_MIN_ADDR_WIDTH || ADDR_WIDTH > FIFO_MAX_ADDR_WIDTH ||
       AF_THRESH > 2**ADDR_WIDTH) begin : g_bad_param
      $error("fifo_wr_ctrl: ADDR_WIDTH or AF_THRESH out of range");
   end

   logic [PTR_W-1:0] r_bin;
   logic [PTR_W-1:0] r_gray;
   logic             r_full;
   logic             r_ovf;

   logic [PTR_W-1:0] w_bin_next;
   logic [PTR_W-1:0] w_gray_next;
   logic [PTR_W-1:0] w_full_cmp;

   assign w_en        = w_inc & ~r_full;
   assign w_bin_next  = r_bin + PTR_W'(w_en);
   assign w_gray_next = PTR_W'(bin2gray(fifo_ptr_t'(w_bin_next)));

   // Exactly DEPTH ahead of the read pointer: in Gray code that is the read
   // pointer with its two top bits inverted.
   assign w_full_cmp  = {~wq2_rptr[ADDR_WIDTH -: 2], wq2_rptr[ADDR_WIDTH-2:0]};

   always_ff @(posedge w_clk) begin
      if (wrst) begin
         r_bin  <= '0;
         r_gray <= '0;
         r_full <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_bin  <= w_bin_next;
         r_gray <= w_gray_next;
         r_full <= (w_gray_next == w_full_cmp);
         // A fresh overflow takes priority over a clear in the same cycle.
         if (w_inc && r_full) begin
            r_ovf <= 1'b1;
         end else if (ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign waddr     = r_bin[ADDR_WIDTH-1:0];
   assign gray_wptr = r_gray;
   assign wfull     = r_full;
   assign wovf      = r_ovf;

`ifdef FIFO_WR_LEVEL_EN
   logic [PTR_W-1:0] w_rbin;
   logic [PTR_W-1:0] r_level;

   fifo_gray2bin #(
      .WIDTH (PTR_W)
   ) u_rptr_g2b (
      .i_gray (wq2_rptr),
      .o_bin  (w_rbin)
   );

   always_ff @(posedge w_clk) begin
      if (wrst) begin
         r_level <= '0;
      end else begin
         r_level <= w_bin_next - w_rbin;
      end
   end

   assign wlevel       = r_level;
   assign walmost_full = (r_level >= PTR_W'(AF_THRESH));
`endif

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Parametrised write-side controller for the dual-clock FIFO, running entirely in the write clock domain. It generalises the fixed 4-bit write pointer logic to any depth, with these changes:
- Gray conversion is arithmetic, not a lookup table.
- The full flag is registered.
- A memory write strobe is generated.
- A sticky overflow flag is added.
The block consumes the read pointer (Gray code), already synchronised into the write domain, and drives the FIFO memory write port and the Gray write pointer sent to the read-domain synchroniser.

Parameters:
- ADDR_WIDTH, 3, memory address width; depth = 2**ADDR_WIDTH; legal range 2..12.
- AF_THRESH, 2**ADDR_WIDTH-2, almost-full threshold in entries (used only with the optional feature).

Ports:
- w_clk  in  1  write-domain clock; all logic on rising edge.
- wrst  in  1  synchronous, active-high reset.
- w_inc  in  1  write request from producer.
- wq2_rptr  in  ADDR_WIDTH+1  read pointer, Gray code, synchronised into w_clk.
- ovf_clr  in  1  clears the sticky overflow flag.
- w_en  out  1  memory write strobe = w_inc & ~wfull (combinational).
- waddr  out  ADDR_WIDTH  memory write address = low ADDR_WIDTH bits of the binary pointer.
- gray_wptr  out  ADDR_WIDTH+1  registered Gray write pointer, to the read-domain synchroniser.
- wfull  out  1  registered full flag.
- wovf  out  1  sticky overflow: a write was attempted while full.

Behaviour:
- Reset (wrst=1 at a w_clk edge): wbin, gray_wptr, wfull and wovf all become 0, so waddr=0 and w_en=w_inc. Reset mid-stream discards the pointer state immediately, with no drain.
- Binary pointer, width ADDR_WIDTH+1:
  - wbin_next = wbin + (w_inc & ~wfull), wrapping modulo 2**(ADDR_WIDTH+1).
  - wbin <= wbin_next.
- Gray pointer: gray_next = wbin_next ^ (wbin_next >> 1); gray_wptr <= gray_next. gray_wptr changes in the same edge as wbin, and only one bit changes per increment.
- Full:
  - wfull <= (gray_next == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]}).
  - wfull asserts on the edge that accepts the DEPTH-th unread write; there is no extra cycle of latency.
  - wfull deasserts on the first edge after wq2_rptr advances (pessimistic by the synchroniser delay; this is by design).
- Write acceptance:
  - A write is accepted when w_inc & ~wfull. Memory writes mem[waddr] on that same edge.
  - A write attempt while full is dropped: the pointer holds and w_en=0.
- Overflow:
  - wovf <= 1 when w_inc & wfull.
  - Otherwise wovf <= 0 when ovf_clr.
  - Otherwise wovf holds.
  - A new overflow and ovf_clr in the same cycle leaves wovf=1 (set wins).
- Wrap-around: after 2**(ADDR_WIDTH+1) accepted writes, wbin returns to 0 and the MSB toggle distinguishes full from empty. No special case is needed.
- Reset wins over all other inputs.

Optional Feature:
- Macro FIFO_WR_LEVEL_EN.
- When defined, two extra outputs are added:
  - wlevel, ADDR_WIDTH+1 bits, registered. wlevel <= wbin_next - gray2bin(wq2_rptr), modulo 2**(ADDR_WIDTH+1). Range 0..DEPTH; reset value 0.
  - walmost_full, 1 bit, combinational = (wlevel >= AF_THRESH). Reset value 0.
- When not defined, both ports and the gray2bin logic are absent. The remaining behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - function bin2gray(width-generic);
  - function gray2bin(width-generic, XOR prefix from MSB);
  - constant FIFO_MIN_ADDR_WIDTH = 2.
- The read-side controller shares the same package.
- One natural sub-module: fifo_gray2bin, a combinational parametrised converter. It is instantiated only under FIFO_WR_LEVEL_EN and is reused by the read side.

Test Plan:
Parameters for all scenarios: ADDR_WIDTH=3, DEPTH=8.
1. Fill from reset:
   - Stimulus: wq2_rptr=0000, w_inc=1 for 10 cycles.
   - Expect: waddr steps 0..7; wfull=1 after the 8th accepted edge; gray_wptr=1100; 8 w_en pulses.
   - Expect: cycles 9-10 are dropped and wovf=1.
2. Drain release:
   - Stimulus: from full, wq2_rptr -> 0001.
   - Expect: wfull=0 on the next edge; one write accepted at waddr=0; wfull=1 again with gray_wptr=1101.
3. Wrap-around:
   - Stimulus: 20 writes, with wq2_rptr tracking gray(wbin-2) each cycle.
   - Expect: wfull never asserts; wbin wraps 15->0; gray_wptr 1000->0000 (one-bit change).
4. Overflow clear:
   - Stimulus: wovf=1; assert ovf_clr with w_inc=0.
   - Expect: wovf=0 next edge.
   - Stimulus: ovf_clr=1 and w_inc=1 while full.
   - Expect: wovf stays 1.
5. Synchronous reset mid-stream:
   - Stimulus: after 5 writes, wrst=1 for 1 cycle while w_inc=1.
   - Expect: gray_wptr=0, waddr=0, wfull=0, wovf=0 after the edge; no pointer increment on the reset edge.
6. FIFO_WR_LEVEL_EN, AF_THRESH=6:
   - Stimulus: 6 writes with wq2_rptr=0000.
   - Expect: wlevel=6 and walmost_full=1.
   - Stimulus: wq2_rptr -> 0011 (rbin 2).
   - Expect: wlevel=4 and walmost_full=0.
